// File: rtl/stc_sched_if.sv
// Operand handshake and stc_core control bundle driven by the job sequencer.
interface stc_sched_if #(
  parameter int N_UNIT   = 32,
  parameter int N_ADDERS = N_UNIT - 1,
  parameter int N_LEVELS = 2 * $clog2(N_UNIT) - 1,
  parameter int TILE_K   = 8
);
  logic                         op_valid;
  logic                         op_ready;
  logic                         core_enable;
  logic [1:0]                   core_in_valid;
  logic [N_LEVELS*N_UNIT-1:0]   core_route_signals;
  logic [N_ADDERS-1:0]          core_add_en;
  logic [N_ADDERS-1:0]          core_bypass_en;
  logic [6*N_ADDERS-1:0]        core_sel;
  logic [2*N_UNIT-1:0]          core_edge_tag;
  logic                         res_valid;
  logic [$clog2(TILE_K)-1:0]    res_idx;

  // Sequencer side: consumes operand valid, drives everything else.
  modport master (
    input  op_valid,
    output op_ready, core_enable, core_in_valid,
    output core_route_signals, core_add_en, core_bypass_en, core_sel, core_edge_tag,
    output res_valid, res_idx
  );

  // Operand source / core / observer side.
  modport slave (
    output op_valid,
    input  op_ready, core_enable, core_in_valid,
    input  core_route_signals, core_add_en, core_bypass_en, core_sel, core_edge_tag,
    input  res_valid, res_idx
  );
endinterface

// File: rtl/stc_sched.sv
// Job sequencer for stc_core: config bank, job latch, A/B operand gating,
// fixed-latency result tagging and completion pulse.
module stc_sched #(
  parameter int N_UNIT   = 32,
  parameter int N_ADDERS = N_UNIT - 1,
  parameter int N_LEVELS = 2 * $clog2(N_UNIT) - 1,
  parameter int TILE_K   = 8,
  parameter int N_CFG    = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we_i,
  input  logic [$clog2(N_CFG)-1:0]   cfg_addr_i,
  input  logic [N_LEVELS*N_UNIT-1:0] cfg_route_i,
  input  logic [N_ADDERS-1:0]        cfg_add_en_i,
  input  logic [N_ADDERS-1:0]        cfg_bypass_en_i,
  input  logic [6*N_ADDERS-1:0]      cfg_sel_i,
  input  logic [2*N_UNIT-1:0]        cfg_edge_tag_i,
  input  logic                       start_i,
  input  logic [$clog2(N_CFG)-1:0]   start_slot_i,
  input  logic [$clog2(TILE_K):0]    n_steps_i,
  output logic                       busy_o,
  output logic                       done_o,
  stc_sched_if.master                bus
);
  localparam int SW = $clog2(TILE_K) + 1;
  localparam int IW = $clog2(TILE_K);

  typedef struct packed {
    logic [N_LEVELS*N_UNIT-1:0] route;
    logic [N_ADDERS-1:0]        add_en;
    logic [N_ADDERS-1:0]        bypass_en;
    logic [6*N_ADDERS-1:0]      sel;
    logic [2*N_UNIT-1:0]        edge_tag;
  } cfg_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_STREAM_B, S_DRAIN, S_DONE} state_t;

  cfg_t   bank_q [N_CFG];
  cfg_t   cfg_q;
  cfg_t   cfg_wr;
  state_t state_q, state_d;
  logic   busy_q, done_q, en_q;
  logic [SW-1:0] nsteps_q, cnt_q;
  logic [PIPE_LAT-1:0]         vld_q;
  logic [PIPE_LAT-1:0][IW-1:0] idx_q;
  logic   hs, push_b, pending;

  assign cfg_wr = '{route: cfg_route_i, add_en: cfg_add_en_i, bypass_en: cfg_bypass_en_i,
                    sel: cfg_sel_i, edge_tag: cfg_edge_tag_i};

  // Operand gating is combinational so a beat is taken in the cycle it is offered.
  always_comb begin
    bus.op_ready      = (state_q == S_LOAD_A) || (state_q == S_STREAM_B);
    bus.core_in_valid = 2'b00;
    if (bus.op_valid && state_q == S_LOAD_A)   bus.core_in_valid = 2'b10;
    if (bus.op_valid && state_q == S_STREAM_B) bus.core_in_valid = 2'b01;
  end

  assign hs     = bus.op_ready & bus.op_valid;
  assign push_b = hs & (state_q == S_STREAM_B);

  // A result is still pending if it sits in any stage before the output stage.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) pending |= vld_q[i];
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start_i) state_d = S_LOAD_A;
      S_LOAD_A:   if (hs) state_d = (nsteps_q == '0) ? S_DRAIN : S_STREAM_B;
      S_STREAM_B: if (hs && (cnt_q + SW'(1) == nsteps_q)) state_d = S_DRAIN;
      S_DRAIN:    if (!pending) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM state, registered status outputs, job latch and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      cfg_q    <= '0;
      nsteps_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      en_q    <= (state_d == S_LOAD_A) || (state_d == S_STREAM_B) || (state_d == S_DRAIN);
      if (state_q == S_IDLE && start_i) begin
        // Bank read sees pre-write contents if a write hits this slot now.
        cfg_q    <= bank_q[start_slot_i];
        nsteps_q <= (n_steps_i > SW'(TILE_K)) ? SW'(TILE_K) : n_steps_i;
        cnt_q    <= '0;
      end
      if (push_b) cnt_q <= cnt_q + SW'(1);
    end
  end

  // Configuration bank writes; independent of the latched job copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CFG; i++) bank_q[i] <= '0;
    end else if (cfg_we_i) begin
      bank_q[cfg_addr_i] <= cfg_wr;
    end
  end

  // Result tag pipeline mirroring the core latency; non-B cycles insert zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q[0] <= push_b;
      idx_q[0] <= push_b ? cnt_q[IW-1:0] : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign busy_o                 = busy_q;
  assign done_o                 = done_q;
  assign bus.core_enable        = en_q;
  assign bus.core_route_signals = cfg_q.route;
  assign bus.core_add_en        = cfg_q.add_en;
  assign bus.core_bypass_en     = cfg_q.bypass_en;
  assign bus.core_sel           = cfg_q.sel;
  assign bus.core_edge_tag      = cfg_q.edge_tag;
  assign bus.res_valid          = vld_q[PIPE_LAT-1];
  assign bus.res_idx            = idx_q[PIPE_LAT-1];
endmodule
